// File: rtl/gsim_sched.sv
// Gauss-Seidel sweep scheduler: loads 16 b samples, issues N_ITER row sweeps to an
// external datapath, drains in-flight rows, then streams the x file out. Option: GSIM_EARLY_STOP_EN.
module gsim_sched #(
  parameter int          N_ITER = 70,
  parameter int          DP_LAT = 3,
  parameter logic [31:0] TOL    = 32'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [15:0] b_in,
  output logic        out_valid,
  output logic [31:0] x_out,
  output logic        busy,
  output logic        dp_clear,
  input  logic        dp_ready,
  output logic        dp_issue,
  output logic [3:0]  dp_row,
  output logic [15:0] dp_b,
  input  logic        dp_ret_valid,
  input  logic [31:0] dp_ret_delta,
  output logic        dp_rd_en,
  output logic [3:0]  dp_rd_row,
  input  logic [31:0] dp_rd_data,
  output logic        err,
  output logic [1:0]  o_dbg_state
);

  localparam int SW = $clog2(N_ITER + 1);
  localparam int OW = $clog2(DP_LAT + 1);

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_sweep_cnt, w_sweep_nxt;
  logic [OW-1:0]   r_outstanding;
  logic            r_send_done, w_send_done_nxt;
  logic            r_out_valid;
  logic [31:0]     r_x_out;
  logic            r_err;
  logic [15:0]     r_b [16];
  logic            w_issue, w_clear, w_rd_en, w_ret_ok, w_early_stop;
  logic [3:0]      w_row;

  // Handshake: a row is issued in any CALC cycle where dp_ready is high and fewer than
  // DP_LAT rows are in flight; each dp_ret_valid retires one in-flight row.
  assign w_row    = {r_cnt[1:0], r_cnt[3:2]};
  assign w_ret_ok = dp_ret_valid && (r_outstanding != '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sweep_nxt     = r_sweep_cnt;
    w_send_done_nxt = r_send_done;
    w_issue         = 1'b0;
    w_clear         = 1'b0;
    w_rd_en         = 1'b0;
    case (r_state)
      RECV: begin
        if (in_en) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_clear     = 1'b1;
            w_sweep_nxt = '0;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_issue = dp_ready && (r_outstanding != OW'(DP_LAT));
        if (w_issue) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            if (r_sweep_cnt == SW'(N_ITER - 1)) begin
              w_sweep_nxt = '0;
              w_state_nxt = DRAIN;
            end else begin
              w_sweep_nxt = r_sweep_cnt + SW'(1);
            end
          end
        end
        if (w_early_stop) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // An early stop can leave cnt mid-sweep; SEND needs it at row 0.
        if (r_outstanding == '0) begin
          w_cnt_nxt       = 4'd0;
          w_send_done_nxt = 1'b0;
          w_state_nxt     = SEND;
        end
      end
      SEND: begin
        if (!r_send_done) begin
          w_rd_en   = 1'b1;
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd15) w_send_done_nxt = 1'b1;
        end else begin
          w_send_done_nxt = 1'b0;
          w_state_nxt     = RECV;
        end
      end
      default: w_state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RECV;
      r_cnt         <= 4'd0;
      r_sweep_cnt   <= '0;
      r_outstanding <= '0;
      r_send_done   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_x_out       <= 32'd0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sweep_cnt   <= w_sweep_nxt;
      r_send_done   <= w_send_done_nxt;
      r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_ret_ok);
      r_out_valid   <= w_rd_en;
      if (w_rd_en) r_x_out <= dp_rd_data;
      if (dp_ret_valid && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  // b is a plain storage array with no reset; the next load overwrites it.
  always_ff @(posedge clk) begin
    if ((r_state == RECV) && in_en) r_b[r_cnt] <= b_in;
  end

`ifdef GSIM_EARLY_STOP_EN
  logic [31:0] r_max_delta, w_max_nxt;
  logic [3:0]  r_ret_cnt;

  assign w_max_nxt    = (dp_ret_delta > r_max_delta) ? dp_ret_delta : r_max_delta;
  assign w_early_stop = w_ret_ok && (r_ret_cnt == 4'd15) && (w_max_nxt < TOL) &&
                        (r_state == CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_delta <= 32'd0;
      r_ret_cnt   <= 4'd0;
    end else if (w_clear) begin
      r_max_delta <= 32'd0;
      r_ret_cnt   <= 4'd0;
    end else if (w_ret_ok) begin
      r_ret_cnt   <= r_ret_cnt + 4'd1;
      r_max_delta <= (r_ret_cnt == 4'd15) ? 32'd0 : w_max_nxt;
    end
  end
`else
  logic w_unused_delta;
  assign w_unused_delta = ^dp_ret_delta;
  assign w_early_stop   = 1'b0;
`endif

  assign out_valid   = r_out_valid;
  assign x_out       = r_x_out;
  assign busy        = (r_state != RECV);
  assign dp_clear    = w_clear;
  assign dp_issue    = w_issue;
  assign dp_row      = w_row;
  assign dp_b        = r_b[w_row];
  assign dp_rd_en    = w_rd_en;
  assign dp_rd_row   = r_cnt;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gsim_sched.sv
// Bench for gsim_sched: behavioural datapath (1-cycle return or silent), row-order model,
// and an x_out scoreboard queue for the SEND phase.
module tb_gsim_sched;

  localparam int N_ITER = 70;

  logic        clk, reset, in_en, dp_ready, dp_ret_valid;
  logic [15:0] b_in, dp_b;
  logic [31:0] dp_ret_delta, dp_rd_data, x_out;
  logic        out_valid, busy, dp_clear, dp_issue, dp_rd_en, err;
  logic [3:0]  dp_row, dp_rd_row;
  logic [1:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] b_model [16];
  logic [31:0] exp_q[$];

  logic ret_pipe, ret_en, ret_force, es_mode;
  int   ret_seen, ret_base;

  gsim_sched #(.N_ITER(N_ITER), .DP_LAT(3), .TOL(32'd16)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .out_valid(out_valid), .x_out(x_out), .busy(busy), .dp_clear(dp_clear),
    .dp_ready(dp_ready), .dp_issue(dp_issue), .dp_row(dp_row), .dp_b(dp_b),
    .dp_ret_valid(dp_ret_valid), .dp_ret_delta(dp_ret_delta),
    .dp_rd_en(dp_rd_en), .dp_rd_row(dp_rd_row), .dp_rd_data(dp_rd_data),
    .err(err), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath model: each issue returns one cycle later when ret_en is set
  always @(posedge clk or negedge reset) begin
    if (!reset) ret_pipe <= 1'b0;
    else        ret_pipe <= ret_en && dp_issue;
  end
  initial ret_seen = 0;
  always @(posedge clk) if (dp_ret_valid) ret_seen <= ret_seen + 1;
  assign dp_ret_valid = ret_pipe | ret_force;
  assign dp_ret_delta = (!es_mode || (ret_seen - ret_base) < 16) ? 32'd1000 : 32'd5;
  assign dp_rd_data   = 32'd100 + {28'd0, dp_rd_row};

  task automatic do_reset();
    reset = 1'b0; in_en = 1'b0; b_in = '0; dp_ready = 1'b0;
    ret_en = 1'b0; ret_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic load_b();
    logic [15:0] v;
    dp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        in_en = 1'b0;
        @(posedge clk); #1;
      end
      v = 16'($urandom);
      b_model[i] = v; b_in = v; in_en = 1'b1;
      #1;
      checks++;
      if (dp_clear !== (i == 15)) begin
        errors++; $display("FAIL load_clear[%0d]: got %b expected %b", i, dp_clear, (i == 15));
      end
    end
    @(posedge clk); #1 in_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
  endtask

  // Runs CALC/DRAIN until the first dp_rd_en, checking issue gating, row order and b lookup.
  task automatic run_calc(input int exp_issues, input bit rand_ready);
    int issues = 0, last_cyc = 0;
    bit done = 0, drain_chk = 0, exp_iss;
    logic [3:0] ib, row;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk); #1;
      dp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_en = 1'($urandom_range(0, 1)); b_in = 16'($urandom);
      #1;
      if (drain_chk) begin
        drain_chk = 0; checks++;
        if (o_dbg_state !== 2'd2) begin
          errors++; $display("FAIL drain_state: got %0d expected 2", o_dbg_state);
        end
      end
      if (dp_rd_en) begin
        done = 1; checks++;
        if (c - last_cyc !== 3) begin
          errors++; $display("FAIL drain_to_send: got %0d cycles expected 3", c - last_cyc);
        end
      end else begin
        exp_iss = dp_ready && (issues < exp_issues);
        checks++;
        if (dp_issue !== exp_iss) begin
          errors++; $display("FAIL issue_gate[%0d]: got %b expected %b", issues, dp_issue, exp_iss);
        end
        if (dp_issue) begin
          ib = issues[3:0]; row = {ib[1:0], ib[3:2]};
          checks++;
          if (dp_row !== row || dp_b !== b_model[row]) begin
            errors++; $display("FAIL issue_row[%0d]: got row %0d b %h expected row %0d b %h",
                               issues, dp_row, dp_b, row, b_model[row]);
          end
          issues++;
          if (issues == exp_issues) begin drain_chk = 1; last_cyc = c; end
        end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL calc_timeout: no dp_rd_en within budget"); end
    checks++;
    if (issues !== exp_issues) begin
      errors++; $display("FAIL issue_count: got %0d expected %0d", issues, exp_issues);
    end
  endtask

  // Called in the first SEND cycle; pops exp_q on every out_valid.
  task automatic check_send();
    int rd_n = 0, ov_n = 0;
    logic [31:0] e;
    in_en = 1'b0;
    for (int c = 0; c < 40 && ov_n < 16; c++) begin
      if (c > 0) begin @(posedge clk); #2; end
      checks++;
      if (dp_rd_en !== (c < 16) || (dp_rd_en && dp_rd_row !== rd_n[3:0])) begin
        errors++; $display("FAIL send_rd[%0d]: got en %b row %0d expected en %b row %0d",
                           c, dp_rd_en, dp_rd_row, (c < 16), rd_n);
      end
      if (dp_rd_en) rd_n++;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (x_out !== e || c !== ov_n + 1) begin
          errors++; $display("FAIL send_x[%0d]: got %0d at cycle %0d expected %0d at cycle %0d",
                             ov_n, x_out, c, e, ov_n + 1);
        end
        ov_n++;
      end
    end
    checks++;
    if (ov_n !== 16 || exp_q.size() !== 0) begin
      errors++; $display("FAIL send_count: got %0d outputs expected 16", ov_n);
    end
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b0 || dp_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL send_return: got busy %b rd_en %b ov %b expected 0 0 0",
                         busy, dp_rd_en, out_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({out_valid, busy, dp_issue, dp_clear, dp_rd_en, err} !== 6'b0 || x_out !== 32'd0 ||
        dp_row !== 4'd0 || dp_rd_row !== 4'd0 || o_dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: got ov%b busy%b iss%b clr%b rd%b err%b x%0h row%0d rdrow%0d st%0d expected all 0",
               tag, out_valid, busy, dp_issue, dp_clear, dp_rd_en, err, x_out, dp_row,
               dp_rd_row, o_dbg_state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1 check_all_zero("reset_state");
  endtask

  task automatic test_full_run();
    do_reset();
    es_mode = 1'b0; ret_en = 1'b1;
    for (int r = 0; r < 16; r++) exp_q.push_back(32'd100 + 32'(r));
    load_b();
    run_calc(N_ITER * 16, 1'b1);
    check_send();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", err); end
  endtask

  task automatic test_no_return();
    int n = 0;
    do_reset();
    load_b();
    ret_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1 dp_ready = 1'b1; #1;
      checks++;
      if (dp_issue !== (n < 3)) begin
        errors++; $display("FAIL no_return_gate[%0d]: got %b expected %b", c, dp_issue, (n < 3));
      end
      if (dp_issue) n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL no_return_count: got %0d expected 3", n); end
  endtask

  task automatic test_err();
    do_reset();
    @(posedge clk); #1 ret_force = 1'b1;
    @(posedge clk); #1 ret_force = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    load_b();
    repeat (5) @(posedge clk);
    #1 checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    do_reset();
    #1 checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    es_mode = 1'b0; ret_en = 1'b1;
    load_b();
    run_calc(N_ITER * 16, 1'b1);
    in_en = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_all_zero("reset_mid_send");
    @(posedge clk); #1 reset = 1'b1;
    load_b();
    do_reset();
  endtask

`ifdef GSIM_EARLY_STOP_EN
  task automatic test_early_stop();
    do_reset();
    ret_en = 1'b1;
    for (int r = 0; r < 16; r++) exp_q.push_back(32'd100 + 32'(r));
    load_b();
    ret_base = ret_seen; es_mode = 1'b1;
    run_calc(33, 1'b0);
    check_send();
    es_mode = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0; in_en = 1'b0; b_in = '0; dp_ready = 1'b0;
    ret_en = 1'b0; ret_force = 1'b0; es_mode = 1'b0; ret_base = 0;
    test_reset();
    test_full_run();
    test_no_return();
    test_err();
    test_reset_mid_send();
`ifdef GSIM_EARLY_STOP_EN
    test_early_stop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
